// File: rtl/mem_controller.sv
// Shared 64 KiB byte-wide memory controller: fetch/data arbitration, 16-bit little-endian words, 4-cycle transfer.
// Optional MEM_ROUND_ROBIN_EN: round-robin tie-break between the two ports instead of data-first priority.
module mem_controller #(
  parameter int MEM_SIZE = 65536,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt_program,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BYTE0 = 2'd1,
    BYTE1 = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [7:0]        mem [0:MEM_SIZE-1];
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] addr_hi_s;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] word_s;
  logic              we_r;
  logic              grant_d_r;
  logic              grant_d_s;
  logic              start_s;
  logic [7:0]        lo_r;
  logic [DATA_W-1:0] if_rdata_r;
  logic [DATA_W-1:0] d_rdata_r;
  logic              if_ack_r;
  logic              d_ack_r;
  logic              busy_r;
`ifdef MEM_ROUND_ROBIN_EN
  logic              last_d_r;
`endif

  // The high byte lives at addr+1, wrapping at the top of the address space
  assign addr_hi_s = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign start_s   = (state_r == IDLE) && (state_next_s == BYTE0);

  // Arbitration between the two ports for the next grant
  always_comb begin
    grant_d_s = 1'b0;
`ifdef MEM_ROUND_ROBIN_EN
    if (d_req && if_req) begin
      grant_d_s = ~last_d_r;
    end else if (d_req) begin
      grant_d_s = 1'b1;
    end else begin
      grant_d_s = 1'b0;
    end
`else
    if (d_req) begin
      grant_d_s = 1'b1;
    end else begin
      grant_d_s = 1'b0;
    end
`endif
  end

  // Next-state logic of the transfer sequencer
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (!halt_program && (if_req || d_req)) begin
          state_next_s = BYTE0;
        end else begin
          state_next_s = IDLE;
        end
      end
      BYTE0:   state_next_s = BYTE1;
      BYTE1:   state_next_s = ACK;
      ACK:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Word delivered at ACK: written data on writes, assembled bytes on reads
  always_comb begin
    if (we_r) begin
      word_s = wdata_r;
    end else begin
      word_s = {mem[addr_hi_s], lo_r};
    end
  end

  // State register and request latches captured at the grant edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      addr_r    <= {ADDR_W{1'b0}};
      wdata_r   <= {DATA_W{1'b0}};
      we_r      <= 1'b0;
      grant_d_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (start_s) begin
        grant_d_r <= grant_d_s;
        addr_r    <= grant_d_s ? d_addr : if_addr;
        we_r      <= grant_d_s & d_we;
        wdata_r   <= grant_d_s ? d_wdata : {DATA_W{1'b0}};
      end
    end
  end

`ifdef MEM_ROUND_ROBIN_EN
  // Remember which port won last; resets to fetch so the first tie goes to data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_d_r <= 1'b0;
    end else if (start_s) begin
      last_d_r <= grant_d_s;
    end
  end
`endif

  // Memory array writes, one byte per cycle; contents survive reset
  always_ff @(posedge clk) begin
    if (we_r && (state_r == BYTE0)) begin
      mem[addr_r] <= wdata_r[7:0];
    end else if (we_r && (state_r == BYTE1)) begin
      mem[addr_hi_s] <= wdata_r[DATA_W-1:8];
    end
  end

  // Registered outputs: ack pulse and rdata load on entry to ACK
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lo_r       <= 8'h00;
      if_rdata_r <= {DATA_W{1'b0}};
      d_rdata_r  <= {DATA_W{1'b0}};
      if_ack_r   <= 1'b0;
      d_ack_r    <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      busy_r   <= (state_next_s != IDLE);
      if_ack_r <= (state_r == BYTE1) && !grant_d_r;
      d_ack_r  <= (state_r == BYTE1) && grant_d_r;
      if (state_r == BYTE0) begin
        lo_r <= mem[addr_r];
      end
      if ((state_r == BYTE1) && grant_d_r) begin
        d_rdata_r <= word_s;
      end else if (state_r == BYTE1) begin
        if_rdata_r <= word_s;
      end
    end
  end

  assign if_rdata = if_rdata_r;
  assign d_rdata  = d_rdata_r;
  assign if_ack   = if_ack_r;
  assign d_ack    = d_ack_r;
  assign busy     = busy_r;

endmodule

// File: doc/mem_controller.md
Name: mem_controller

Overview:
- Shared main-memory controller directly downstream of the CPU's fetch and execute/memory stages.
- Owns the 64 KiB byte-wide memory array.
- Arbitrates two requesters: an instruction-fetch read port and a data read/write port.
- Assembles each 16-bit word from two byte accesses and returns it with a one-cycle acknowledge.

Parameters:
- MEM_SIZE, 65536, memory size in bytes; addresses wrap modulo MEM_SIZE.
- ADDR_W, 16, address width in bits.
- DATA_W, 16, word width in bits; fixed at 2 bytes.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous active-low reset.
- halt_program  input  1  when high, no new grants; an in-flight transfer completes.
- if_req  input  1  fetch read request; held high until if_ack.
- if_addr  input  ADDR_W  fetch byte address.
- if_rdata  output  DATA_W  fetch read data; valid while if_ack=1.
- if_ack  output  1  one-cycle fetch completion pulse.
- d_req  input  1  data request; held high until d_ack.
- d_we  input  1  1=write, 0=read; sampled at grant.
- d_addr  input  ADDR_W  data byte address.
- d_wdata  input  DATA_W  write data; sampled at grant.
- d_rdata  output  DATA_W  data read data; valid while d_ack=1.
- d_ack  output  1  one-cycle data completion pulse.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - if_ack, d_ack, busy, if_rdata and d_rdata are all 0.
  - Latched address, data, we and grant registers are cleared.
  - Memory array contents are not cleared.
- Word format is little-endian: byte at addr is the low byte; byte at (addr+1) mod MEM_SIZE is the high byte. Unaligned addresses are legal.
- FSM states: IDLE, BYTE0, BYTE1, ACK.
- IDLE: if halt_program=0 and any req=1, grant one port and go to BYTE0. At the grant edge, latch addr, we and wdata, and record the granted port. Otherwise stay in IDLE.
- Default arbitration: fixed priority, data port over fetch port.
- BYTE0: read or write the low byte at addr; go to BYTE1.
- BYTE1: read or write the high byte at addr+1 (wraps 0xFFFF→0x0000); go to ACK.
- ACK:
  - Assert only the granted port's ack for exactly one cycle.
  - Drive that port's rdata with the assembled word; on writes, drive the written word.
  - Go to IDLE.
- Latency: req high in IDLE at edge N gives ack high during cycle N+3. The earliest next grant is edge N+4, so throughput is one word per 4 cycles.
- rdata outputs hold their last value after ack and change only at the next ACK of the same port.
- A requester that drops req before ack has no effect; the granted transfer still completes and acks.
- If the requester samples the ack and drops req in the same cycle, no duplicate grant occurs, because IDLE is re-entered only after ACK.
- halt_program rising mid-transfer does not stall it; the transfer finishes, then the controller stays in IDLE while halt_program=1.
- Reset mid-transfer aborts with no ack. A write aborted after BYTE0 leaves the low byte written and the high byte unchanged.
- A simultaneous read of the fetch port and write of the data port is resolved by arbitration only; ports never overlap.

Optional Feature:
- Macro: MEM_ROUND_ROBIN_EN.
- Defined:
  - When both reqs are high in IDLE, grant the port not granted last.
  - The last-grant register resets to "fetch", so the first tie goes to data.
  - A single requester is always granted.
- Undefined: fixed data-over-fetch priority; no last-grant register.

Test Plan:
- Write then read: d_req, d_we=1, d_addr=0x0010, d_wdata=0xBEEF at edge N → d_ack in cycle N+3; mem[0x0010]=0xEF, mem[0x0011]=0xBE. A following read of 0x0010 → d_rdata=0xBEEF with d_ack.
- Fetch: if_req, if_addr=0x0010 after the above write → if_rdata=0xBEEF, if_ack 3 cycles after grant; d_ack stays 0.
- Tie: if_req and d_req both rise at edge N → d_ack in cycle N+3 and if_ack in cycle N+7 (data first). With MEM_ROUND_ROBIN_EN, a second tie afterwards acks fetch first.
- Wrap: write 0x1234 at d_addr=0xFFFF → mem[0xFFFF]=0x34, mem[0x0000]=0x12; read back at 0xFFFF returns 0x1234.
- Reset mid-op: rst low during BYTE1 of a write of 0xAAAA to 0x0020 (previously 0x0000) → no ack, all outputs 0, mem[0x0020]=0xAA, mem[0x0021]=0x00. A later request completes normally.
- Halt: halt_program=1 with d_req high for 10 cycles → no ack, busy=0. Lowering halt_program at edge M → d_ack in cycle M+3.
